// File: rtl/ddr_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_arb_pkg
// Purpose  : Shared widths, FSM encoding and command-select constants for
//            the DDR request arbiter.
// Revision : 1.0  initial release
// ============================================================================
package ddr_arb_pkg;

    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;
    localparam int LEVEL_W = 7;
    localparam int STAT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_REFRESH       = 3'd1,
        ST_READ          = 3'd2,
        ST_WRITE         = 3'd3,
        ST_WRITE_RELEASE = 3'd4
    } arb_state_e;

    // One-hot controller command: {refresh, write, read}
    typedef logic [2:0] cmd_t;
    localparam cmd_t CMD_NONE    = 3'b000;
    localparam cmd_t CMD_READ    = 3'b001;
    localparam cmd_t CMD_WRITE   = 3'b010;
    localparam cmd_t CMD_REFRESH = 3'b100;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    function automatic cmd_t state_cmd(input arb_state_e s);
        case (s)
            ST_REFRESH: return CMD_REFRESH;
            ST_READ:    return CMD_READ;
            ST_WRITE:   return CMD_WRITE;
            default:    return CMD_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_request_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr_request_arbiter_if
// Purpose  : Client-side and controller-side signals of the DDR arbiter.
//            slave = arbiter view, master = surrounding system view.
// Revision : 1.0  initial release
// ============================================================================
interface ddr_request_arbiter_if
    import ddr_arb_pkg::*;
();
    logic                rd_req;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_ack;
    logic [DATA_W-1:0]   rd_data;
    logic                wr_valid;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_ready;
    logic                ddr_read;
    logic [ADDR_W-1:0]   ddr_read_addr;
    logic                ddr_read_ack;
    logic [DATA_W-1:0]   ddr_read_data;
    logic                ddr_write;
    logic [ADDR_W-1:0]   ddr_write_addr;
    logic [DATA_W-1:0]   ddr_write_data;
    logic                ddr_write_ack;
    logic                ddr_refresh;
    logic [LEVEL_W-1:0]  fifo_level;
    logic                refresh_missed;
    logic [STAT_W-1:0]   stat_reads;
    logic [STAT_W-1:0]   stat_writes;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data,
               ddr_read_ack, ddr_read_data, ddr_write_ack,
        output rd_ack, rd_data, wr_ready,
               ddr_read, ddr_read_addr, ddr_write, ddr_write_addr, ddr_write_data,
               ddr_refresh, fifo_level, refresh_missed, stat_reads, stat_writes
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data,
               ddr_read_ack, ddr_read_data, ddr_write_ack,
        input  rd_ack, rd_data, wr_ready,
               ddr_read, ddr_read_addr, ddr_write, ddr_write_addr, ddr_write_data,
               ddr_refresh, fifo_level, refresh_missed, stat_reads, stat_writes
    );

endinterface
`default_nettype wire

// File: rtl/ddr_request_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ddr_write_fifo
// Purpose  : Synchronous FIFO for posted writes; reports level/full/empty.
// Revision : 1.0  initial release
// ============================================================================
module ddr_write_fifo #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 40,
    parameter int LEVEL_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic [WIDTH-1:0]   head_o,
    output logic [LEVEL_W-1:0] level_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LEVEL_W-1:0] level_q;
    logic               push_ok;
    logic               pop_ok;

    assign full_o  = (level_q == LEVEL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Storage carries no reset: contents are meaningless while level is 0.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr_request_arbiter
// Purpose  : Merges VGA reads, posted draw-engine writes and auto-refresh onto
//            the DDR controller. Optional macro ARB_STATS_EN adds counters.
// Revision : 1.0  initial release
// ============================================================================
module ddr_request_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int FIFO_DEPTH       = 16,
    parameter int REFRESH_INTERVAL = 1000,
    parameter int GUARD_CYCLES     = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    ddr_request_arbiter_if.slave  bus
);

    localparam int REF_W = $clog2(REFRESH_INTERVAL + 1);
    localparam int GRD_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(REFRESH_INTERVAL);
    localparam logic [GRD_W-1:0] GRD_RELOAD = GRD_W'(GUARD_CYCLES);

    arb_state_e         state_q, state_d;
    cmd_t               cmd_q;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    wr_entry_t          wr_entry_q, wr_entry_d;
    logic               ready_q;
    logic               rd_ack_d;
    logic               fifo_pop_d;

    logic [REF_W-1:0]   ref_cnt_q;
    logic               ref_reload_d;
    logic               ref_pending_q, ref_pending_d;
    logic               missed_q;
    logic [GRD_W-1:0]   guard_q;
    logic               rd_ack_prev_q, wr_ack_prev_q;
    logic               ack_rise_d;

    wr_entry_t          fifo_head;
    wr_entry_t          fifo_in;
    logic [LEVEL_W-1:0] fifo_level;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;

    assign fifo_in   = '{addr: bus.wr_addr, data: bus.wr_data};
    assign fifo_push = bus.wr_valid & ready_q & ~fifo_full;

    ddr_write_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   ($bits(wr_entry_t)),
        .LEVEL_W (LEVEL_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop_d),
        .data_i  (fifo_in),
        .head_o  (fifo_head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        wr_entry_d = wr_entry_q;
        rd_ack_d   = 1'b0;
        fifo_pop_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ref_pending_q && (guard_q == '0)) begin
                    state_d = ST_REFRESH;
                end else if (bus.rd_req) begin
                    state_d   = ST_READ;
                    rd_addr_d = bus.rd_addr;
                end else if (!fifo_empty) begin
                    state_d    = ST_WRITE;
                    wr_entry_d = fifo_head;
                end
            end
            ST_REFRESH: state_d = ST_IDLE;
            ST_READ: begin
                if (bus.ddr_read_ack) begin
                    rd_ack_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (bus.ddr_write_ack) begin
                    fifo_pop_d = 1'b1;
                    state_d    = ST_WRITE_RELEASE;
                end
            end
            // The write ack is a level; a new command must wait for it to fall.
            ST_WRITE_RELEASE: begin
                if (!bus.ddr_write_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_NONE;
            rd_addr_q  <= '0;
            wr_entry_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= state_cmd(state_d);
            rd_addr_q  <= rd_addr_d;
            wr_entry_q <= wr_entry_d;
            ready_q    <= 1'b1;
        end
    end

    // A reload coinciding with the refresh being issued re-arms pending.
    always_comb begin
        ref_reload_d  = (ref_cnt_q == '0);
        ref_pending_d = ref_pending_q;
        if (state_q == ST_REFRESH) ref_pending_d = 1'b0;
        if (ref_reload_d)          ref_pending_d = 1'b1;
        ack_rise_d = (bus.ddr_read_ack & ~rd_ack_prev_q) |
                     (bus.ddr_write_ack & ~wr_ack_prev_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q     <= REF_RELOAD;
            ref_pending_q <= 1'b0;
            missed_q      <= 1'b0;
            guard_q       <= GRD_RELOAD;
            rd_ack_prev_q <= 1'b0;
            wr_ack_prev_q <= 1'b0;
        end else begin
            ref_cnt_q     <= ref_reload_d ? REF_RELOAD : ref_cnt_q - 1'b1;
            ref_pending_q <= ref_pending_d;
            if (ref_reload_d && ref_pending_q && (state_q != ST_REFRESH)) begin
                missed_q <= 1'b1;
            end
            rd_ack_prev_q <= bus.ddr_read_ack;
            wr_ack_prev_q <= bus.ddr_write_ack;
            if (ack_rise_d || (state_q == ST_REFRESH)) begin
                guard_q <= GRD_RELOAD;
            end else if (guard_q != '0) begin
                guard_q <= guard_q - 1'b1;
            end
        end
    end

    assign bus.rd_ack         = rd_ack_d;
    assign bus.rd_data        = rd_ack_d ? bus.ddr_read_data : '0;
    assign bus.wr_ready       = ready_q & ~fifo_full;
    assign bus.ddr_read       = |(cmd_q & CMD_READ);
    assign bus.ddr_write      = |(cmd_q & CMD_WRITE);
    assign bus.ddr_refresh    = |(cmd_q & CMD_REFRESH);
    assign bus.ddr_read_addr  = rd_addr_q;
    assign bus.ddr_write_addr = wr_entry_q.addr;
    assign bus.ddr_write_data = wr_entry_q.data;
    assign bus.fifo_level     = fifo_level;
    assign bus.refresh_missed = missed_q;

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] stat_rd_q;
    logic [STAT_W-1:0] stat_wr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            if (rd_ack_d && (stat_rd_q != '1))   stat_rd_q <= stat_rd_q + 1'b1;
            if (fifo_pop_d && (stat_wr_q != '1)) stat_wr_q <= stat_wr_q + 1'b1;
        end
    end

    assign bus.stat_reads  = stat_rd_q;
    assign bus.stat_writes = stat_wr_q;
`else
    assign bus.stat_reads  = '0;
    assign bus.stat_writes = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_request_arbiter
// Purpose  : Directed self-checking bench with a simple DDR controller model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ddr_request_arbiter;
    import ddr_arb_pkg::*;

    localparam int DEPTH = 16;
    localparam int RI    = 200;
    localparam int GC    = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr_request_arbiter_if bus ();

    ddr_request_arbiter #(
        .FIFO_DEPTH       (DEPTH),
        .REFRESH_INTERVAL (RI),
        .GUARD_CYCLES     (GC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Controller model knobs
    int          rd_lat   = 20;
    logic [15:0] rd_resp  = 16'hBEEF;
    logic        wr_stall = 1'b0;
    int          wr_lat   = 2;
    int          wr_hold  = 0;

    // Monitor state
    int          refresh_pulses = 0;
    int          refresh_run    = 0;
    int          refresh_max    = 0;
    int          excl_err       = 0;
    int          overlap_err    = 0;
    int          order_q[$];
    logic [23:0] wlog_a[$];
    logic [15:0] wlog_d[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Read side: ack ddr_read after rd_lat cycles
    initial begin
        int rd_cnt;
        rd_cnt = 0;
        bus.ddr_read_ack  = 1'b0;
        bus.ddr_read_data = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.ddr_read_ack = 1'b0;
            if (bus.ddr_read) begin
                rd_cnt++;
                if (rd_cnt >= rd_lat) begin
                    bus.ddr_read_ack  = 1'b1;
                    bus.ddr_read_data = rd_resp;
                    rd_cnt = 0;
                end
            end else begin
                rd_cnt = 0;
            end
        end
    end

    // Write side: level ack, held wr_hold cycles after ddr_write drops
    initial begin
        int wcnt;
        int hold_cnt;
        wcnt = 0;
        hold_cnt = 0;
        bus.ddr_write_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.ddr_write) begin
                hold_cnt = 0;
                if (!wr_stall) begin
                    wcnt++;
                    if (wcnt >= wr_lat) bus.ddr_write_ack = 1'b1;
                end
            end else begin
                wcnt = 0;
                if (bus.ddr_write_ack) begin
                    if (hold_cnt >= wr_hold) bus.ddr_write_ack = 1'b0;
                    else hold_cnt++;
                end
            end
        end
    end

    // Monitor on the falling edge
    initial begin
        logic prev_r, prev_w, prev_f;
        prev_r = 1'b0; prev_w = 1'b0; prev_f = 1'b0;
        forever begin
            @(negedge clk);
            if (int'(bus.ddr_read) + int'(bus.ddr_write) + int'(bus.ddr_refresh) > 1) excl_err++;
            if (bus.ddr_refresh) begin
                refresh_run++;
                if (refresh_run > refresh_max) refresh_max = refresh_run;
                if (!prev_f) begin
                    refresh_pulses++;
                    order_q.push_back(4);
                end
            end else begin
                refresh_run = 0;
            end
            if (bus.ddr_read && !prev_r) order_q.push_back(1);
            if (bus.ddr_write && !prev_w) begin
                order_q.push_back(2);
                wlog_a.push_back(bus.ddr_write_addr);
                wlog_d.push_back(bus.ddr_write_data);
                if (bus.ddr_write_ack) overlap_err++;
            end
            prev_r = bus.ddr_read;
            prev_w = bus.ddr_write;
            prev_f = bus.ddr_refresh;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int cnt0;
        logic found;

        bus.rd_req   = 1'b0;
        bus.rd_addr  = '0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_ddr_read",    bus.ddr_read, 0);
        chk("rst_ddr_write",   bus.ddr_write, 0);
        chk("rst_ddr_refresh", bus.ddr_refresh, 0);
        chk("rst_wr_ready",    bus.wr_ready, 0);
        chk("rst_fifo_level",  bus.fifo_level, 0);
        chk("rst_missed",      bus.refresh_missed, 0);
        chk("rst_rd_ack",      bus.rd_ack, 0);
        rst = 1'b0;
        tick();
        chk("wr_ready_after_rst", bus.wr_ready, 1);

        // Idle refresh: 3 intervals plus margin
        cnt0 = refresh_pulses;
        repeat (3 * (RI + 1) + 30) tick();
        chk("idle_refresh_count", refresh_pulses - cnt0, 3);
        chk("refresh_width",      refresh_max, 1);
        chk("idle_missed",        bus.refresh_missed, 0);

        // Single read
        rd_lat = 20;
        bus.rd_addr = 24'h012345;
        bus.rd_req  = 1'b1;
        tick();
        chk("read_latency", bus.ddr_read, 1);
        chk("read_addr",    bus.ddr_read_addr, 24'h012345);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.rd_ack) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("read_ack_seen", found, 1);
        chk("read_data",     bus.rd_data, 16'hBEEF);
        bus.rd_req = 1'b0;
        tick();
        chk("read_drop",      bus.ddr_read, 0);
        chk("read_ack_pulse", bus.rd_ack, 0);

        // Write burst against a stalled controller
        wr_stall = 1'b1;
        wlog_a.delete();
        wlog_d.delete();
        accepted = 0;
        for (int i = 0; i < 17; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 24'h100000 + 24'(i);
            bus.wr_data  = 16'hA000 + 16'(i);
            if (bus.wr_ready) accepted++;
            tick();
        end
        bus.wr_valid = 1'b0;
        chk("burst_accepted", accepted, 16);
        chk("burst_wr_ready", bus.wr_ready, 0);
        chk("burst_level",    bus.fifo_level, 16);
        chk("burst_stalled",  bus.ddr_write, 1);
        wr_stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (bus.fifo_level == 0 && !bus.ddr_write) begin
                found = 1'b1;
                break;
            end
        end
        repeat (4) tick();
        chk("drain_done",  found, 1);
        chk("drain_count", wlog_a.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_entry", {wlog_a[i], wlog_d[i]},
                {24'h100000 + 24'(i), 16'hA000 + 16'(i)});
        end

        // Level write ack held after ddr_write drops
        wr_hold = 5;
        wlog_a.delete();
        wlog_d.delete();
        overlap_err = 0;
        for (int i = 0; i < 2; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 24'h110000 + 24'(i);
            bus.wr_data  = 16'hC000 + 16'(i);
            tick();
        end
        bus.wr_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.fifo_level == 0 && !bus.ddr_write && !bus.ddr_write_ack) begin
                found = 1'b1;
                break;
            end
        end
        chk("acklvl_done",    found, 1);
        chk("acklvl_writes",  wlog_a.size(), 2);
        chk("acklvl_overlap", overlap_err, 0);
        wr_hold = 0;

        // Priority: refresh, then read, then write, all pending together
        cnt0 = refresh_pulses;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (refresh_pulses != cnt0) begin
                found = 1'b1;
                break;
            end
        end
        chk("prio_sync", found, 1);
        wr_hold = 100000;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 24'h200001;
        bus.wr_data  = 16'h5A01;
        tick();
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ddr_write_ack && !bus.ddr_write) break;
            tick();
        end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 24'h200002;
        bus.wr_data  = 16'h5A02;
        tick();
        bus.wr_valid = 1'b0;
        rd_lat = 3;
        bus.rd_addr = 24'h0ABCDE;
        bus.rd_req  = 1'b1;
        repeat (205) tick();
        chk("prio_hold_level", bus.fifo_level, 1);
        chk("prio_hold_idle",  {bus.ddr_read, bus.ddr_write, bus.ddr_refresh}, 0);
        order_q.delete();
        wr_hold = 0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.rd_ack) begin
                found = 1'b1;
                break;
            end
        end
        bus.rd_req = 1'b0;
        chk("prio_read_done", found, 1);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.fifo_level == 0 && !bus.ddr_write && !bus.ddr_write_ack) break;
        end
        repeat (4) tick();
        chk("prio_order_len", order_q.size(), 3);
        chk("prio_first",  order_q[0], 4);
        chk("prio_second", order_q[1], 1);
        chk("prio_third",  order_q[2], 2);
        chk("prio_missed", bus.refresh_missed, 0);

        // Back-to-back reads keep the guard busy and starve refresh
        rd_lat = 1;
        bus.rd_addr = 24'h001000;
        bus.rd_req  = 1'b1;
        cnt0 = refresh_pulses;
        repeat (2 * (RI + 1) + 50) tick();
        chk("starve_missed",  bus.refresh_missed, 1);
        chk("starve_no_refr", refresh_pulses - cnt0, 0);
        bus.rd_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (refresh_pulses != cnt0) begin
                found = 1'b1;
                break;
            end
        end
        chk("starve_recover", found, 1);
        chk("missed_sticky",  bus.refresh_missed, 1);

        // Reset during an outstanding write
        wr_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 24'h300000 + 24'(i);
            bus.wr_data  = 16'hD000 + 16'(i);
            tick();
        end
        bus.wr_valid = 1'b0;
        tick();
        chk("rmw_active", bus.ddr_write, 1);
        chk("rmw_level",  bus.fifo_level, 3);
        #1 rst = 1'b1;
        #1;
        chk("rmw_write_drop",  bus.ddr_write, 0);
        chk("rmw_level_clear", bus.fifo_level, 0);
        chk("rmw_missed_clr",  bus.refresh_missed, 0);
        chk("rmw_ready_rst",   bus.wr_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        wr_stall = 1'b0;
        tick();
        chk("rmw_ready_after", bus.wr_ready, 1);
        chk("rmw_level_after", bus.fifo_level, 0);
        chk("rmw_write_after", bus.ddr_write, 0);

`ifndef ARB_STATS_EN
        chk("stat_reads_tied",  bus.stat_reads, 0);
        chk("stat_writes_tied", bus.stat_writes, 0);
`endif
        chk("cmd_exclusive", excl_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
